// File: rtl/udm_timer_slave.sv
// udm_timer_slave
//   Memory-mapped down-counting timer plus a free-running 64-bit cycle counter.
//   The block is a slave on the udm split bus. It drives a level interrupt.
//
// Ports
//   clk_i, rst_i   clock and synchronous active-high reset
//   bus_req_i      request valid
//   bus_we_i       request is a write (1) or a read (0)
//   bus_addr_bi    byte address, word aligned
//   bus_be_bi      byte enables, used by writes only
//   bus_wdata_bi   write data
//   bus_ack_o      always equal to bus_req_i; the slave is always ready
//   bus_resp_o     one-cycle pulse, one cycle after a read is accepted
//   bus_rdata_bo   read data; zero whenever bus_resp_o is low
//   irq_o          STATUS.expired & CTRL.irq_en
//
// Register map (byte offset from BASE_ADDR)
//   0x00 CTRL   [0]en [1]autoreload [2]irq_en
//   0x04 LOAD
//   0x08 COUNT
//   0x0C STATUS [0]expired (write 1 to clear)
//   0x10 PRESC  [15:0]
//   0x14 CYC_LO (a read also captures the high word)
//   0x18 CYC_HI (the high word captured by the last CYC_LO read)
//   0x1C reserved
module udm_timer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o
);

    // Replace only the bytes that are enabled; the other bytes keep their old value.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction

    logic        en_q, en_d, ar_q, ar_d, ie_q, ie_d;
    logic [31:0] load_q, load_d, count_q, count_d;
    logic        expired_q, expired_d;
    logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic [63:0] cyc_q, cyc_d;
    logic [31:0] snap_q, snap_d;
    logic        resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;

    logic        in_win, acc_wr, acc_rd, tick, expire;
    logic [2:0]  off;
    logic [31:0] ctrl_merged, presc_merged;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^bus_addr_bi[1:0];

    assign in_win = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
    assign off    = bus_addr_bi[4:2];
    assign acc_wr = bus_req_i & bus_we_i & in_win;
    assign acc_rd = bus_req_i & ~bus_we_i & in_win;

    assign tick   = en_q && (pcnt_q == presc_q);
    assign expire = tick && (count_q == 32'd0);

    assign ctrl_merged  = byte_merge({29'd0, ie_q, ar_q, en_q}, bus_wdata_bi, bus_be_bi);
    assign presc_merged = byte_merge({16'd0, presc_q}, bus_wdata_bi, bus_be_bi);

    always_comb begin
        en_d      = en_q;
        ar_d      = ar_q;
        ie_d      = ie_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        cyc_d     = cyc_q + 64'd1;
        snap_d    = snap_q;
        resp_d    = acc_rd;
        rdata_d   = 32'd0;

        // Prescaler: held at zero while disabled. It wraps on a tick.
        if (!en_q || tick)
            pcnt_d = 16'd0;
        else
            pcnt_d = pcnt_q + 16'd1;

        // Timer events, applied before bus writes so that bus writes take priority.
        if (tick) begin
            if (count_q != 32'd0)
                count_d = count_q - 32'd1;
            else if (ar_q)
                count_d = load_q;
            else
                en_d = 1'b0;
        end

        if (acc_wr) begin
            case (off)
                3'd0: {ie_d, ar_d, en_d} = ctrl_merged[2:0];
                3'd1: load_d  = byte_merge(load_q, bus_wdata_bi, bus_be_bi);
                3'd2: count_d = byte_merge(count_q, bus_wdata_bi, bus_be_bi);
                3'd3: if (bus_be_bi[0] && bus_wdata_bi[0]) expired_d = 1'b0;
                3'd4: begin
                    presc_d = presc_merged[15:0];
                    pcnt_d  = 16'd0;
                end
                default: ;
            endcase
        end

        // An expiry in the same cycle as a write-1-to-clear leaves the flag set.
        if (expire)
            expired_d = 1'b1;

        if (acc_rd) begin
            case (off)
                3'd0: rdata_d = {29'd0, ie_q, ar_q, en_q};
                3'd1: rdata_d = load_q;
                3'd2: rdata_d = count_q;
                3'd3: rdata_d = {31'd0, expired_q};
                3'd4: rdata_d = {16'd0, presc_q};
                3'd5: begin
                    rdata_d = cyc_q[31:0];
                    snap_d  = cyc_q[63:32];
                end
                3'd6: rdata_d = snap_q;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            ie_q      <= 1'b0;
            load_q    <= 32'd0;
            count_q   <= 32'd0;
            expired_q <= 1'b0;
            presc_q   <= 16'd0;
            pcnt_q    <= 16'd0;
            cyc_q     <= 64'd0;
            snap_q    <= 32'd0;
            resp_q    <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            en_q      <= en_d;
            ar_q      <= ar_d;
            ie_q      <= ie_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            cyc_q     <= cyc_d;
            snap_q    <= snap_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus_ack_o    = bus_req_i;
    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;
    assign irq_o        = expired_q & ie_q;

endmodule

// File: tb/tb_udm_timer_slave.sv
module tb_udm_timer_slave;

    localparam logic [31:0] B = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, resp, irq;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    udm_timer_slave #(.BASE_ADDR(B)) dut (
        .clk_i(clk), .rst_i(rst),
        .bus_req_i(req), .bus_we_i(we), .bus_addr_bi(addr),
        .bus_be_bi(be), .bus_wdata_bi(wdata),
        .bus_ack_o(ack), .bus_resp_o(resp), .bus_rdata_bo(rdata),
        .irq_o(irq)
    );

    // Inputs change #1 after a rising edge. Each bus task uses exactly one edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = 4'h0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic r);
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
        r = resp; d = rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        logic [31:0] d, exp;
        logic r;
        rst = 1'b1;
        // A write and a read arriving during reset must have no effect.
        do_write(B + 32'h00, 32'h7, 4'hF);
        req = 1'b1; we = 1'b0; addr = B;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL reset_ack got %b want 1", ack); end
        @(posedge clk); #1;
        req = 1'b0;
        checks++;
        if (resp !== 1'b0 || rdata !== 32'd0 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got resp=%b rdata=%h irq=%b want 0/0/0", resp, rdata, irq);
        end
        rst = 1'b0;  // reset was sampled at the last edge, so the cycle counter is 0 now
        for (int i = 0; i < 8; i++) begin
            do_read(B + 32'(i * 4), d, r);
            // CYC_LO reads the number of edges since reset. The read at offset i is accepted i edges after release.
            exp = (i == 5) ? 32'd5 : 32'd0;
            checks++;
            if (r !== 1'b1 || d !== exp) begin
                errors++; $display("FAIL reset_read_%0d got resp=%b data=%h want 1/%h", i, r, d, exp);
            end
        end
        idle(1);
        checks++;
        if (resp !== 1'b0 || rdata !== 32'd0 || irq !== 1'b0) begin
            errors++; $display("FAIL idle_after_read got resp=%b rdata=%h irq=%b want 0/0/0", resp, rdata, irq);
        end
    endtask

    task automatic test_autoreload;
        do_write(B + 32'h04, 32'd3, 4'hF);
        do_write(B + 32'h10, 32'd0, 4'hF);
        do_write(B + 32'h08, 32'd3, 4'hF);
        do_write(B + 32'h00, 32'h7, 4'hF);   // en, autoreload, irq_en
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            checks++;
            if (irq !== (k == 4)) begin
                errors++; $display("FAIL autoreload_tick%0d irq got %b want %b", k, irq, (k == 4));
            end
        end
        do_write(B + 32'h0C, 32'h1, 4'hF);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL autoreload_clear irq got %b want 0", irq); end
        idle(2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL autoreload_gap irq got %b want 0", irq); end
        idle(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL autoreload_period irq got %b want 1", irq); end
        do_write(B + 32'h00, 32'h0, 4'hF);
        do_write(B + 32'h0C, 32'h1, 4'hF);
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        logic r;
        do_write(B + 32'h08, 32'd2, 4'hF);
        do_write(B + 32'h10, 32'd4, 4'hF);
        do_write(B + 32'h00, 32'h1, 4'hF);
        idle(14);
        do_read(B + 32'h0C, d, r);  // accepted at clock 15 and sampled before expiry
        checks++;
        if (r !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL oneshot_before got %b/%h want 1/0", r, d); end
        do_read(B + 32'h0C, d, r);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL oneshot_expired got %h want 1", d); end
        do_read(B + 32'h00, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL oneshot_en_cleared got %h want 0", d); end
        do_read(B + 32'h08, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL oneshot_count got %h want 0", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq got %b want 0", irq); end
        do_write(B + 32'h0C, 32'h1, 4'hF);
    endtask

    task automatic test_w1c_race;
        do_write(B + 32'h10, 32'd0, 4'hF);
        do_write(B + 32'h04, 32'd1, 4'hF);
        do_write(B + 32'h08, 32'd1, 4'hF);
        do_write(B + 32'h00, 32'h7, 4'hF);
        idle(1);                              // count 1 -> 0
        do_write(B + 32'h0C, 32'h1, 4'hF);    // clear in the expiry cycle
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_race irq got %b want 1", irq); end
        do_write(B + 32'h00, 32'h4, 4'hF);    // stop the timer but keep irq_en
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_hold irq got %b want 1", irq); end
        do_write(B + 32'h0C, 32'h1, 4'hF);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear irq got %b want 0", irq); end
    endtask

    task automatic test_byte_enable;
        logic [31:0] d;
        logic r;
        do_write(B + 32'h04, 32'd0, 4'hF);
        do_write(B + 32'h04, 32'hAABBCCDD, 4'b0101);
        do_read(B + 32'h04, d, r);
        checks++;
        if (r !== 1'b1 || d !== 32'h00BB00DD) begin
            errors++; $display("FAIL byte_enable got %b/%h want 1/00bb00dd", r, d);
        end
    endtask

    task automatic test_cycle_counter;
        logic [31:0] d;
        logic r;
        force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
        do_read(B + 32'h14, d, r);
        release dut.cyc_q;
        checks++;
        if (r !== 1'b1 || d !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL cyc_lo got %b/%h want 1/ffffffff", r, d);
        end
        do_read(B + 32'h18, d, r);
        checks++;
        if (r !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL cyc_hi got %b/%h want 1/0", r, d); end
    endtask

    task automatic test_back_to_back;
        req = 1'b1; we = 1'b0; addr = B + 32'h1C;
        @(posedge clk); #1;
        addr = 32'h0000_2000;
        checks++;
        if (resp !== 1'b1 || rdata !== 32'd0) begin
            errors++; $display("FAIL b2b_reserved got %b/%h want 1/0", resp, rdata);
        end
        @(posedge clk); #1;
        req = 1'b0;
        checks++;
        if (resp !== 1'b0 || rdata !== 32'd0) begin
            errors++; $display("FAIL b2b_outside got %b/%h want 0/0", resp, rdata);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'h0;
        @(posedge clk); #1;
        test_reset();
        test_autoreload();
        test_oneshot();
        test_w1c_race();
        test_byte_enable();
        test_cycle_counter();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
